char_feeder: RTL and testbench

CHAR_FEEDER -- requirements
Module: char_feeder

---
 rtl/char_feeder.sv | 94 +++++++++
 tb/tb_char_feeder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/char_feeder.sv
// Character feeder: a DEPTH-entry circular FIFO that presents one registered char per clock
// to the identifier FSM, substituting FILL whenever the buffer is empty.
module char_feeder #(
    parameter int         DEPTH = 8,
    parameter logic [7:0] FILL  = 8'h20
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    input  logic                     pause,
    output logic [7:0]               char,
    output logic                     char_vld,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf
);

    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [7:0]    r_char;
    logic          r_char_vld;
    logic          r_ovf;

    logic          w_full;
    logic          w_wr_acc;
    logic          w_wr_drop;
    logic          w_pop;

    // Acceptance and pop both look only at the registered count, so a pop on a full
    // buffer never makes room for a write on the same edge.
    always_comb begin
        w_full    = (r_count == DEPTH_C);
        w_wr_acc  = wr_en && !w_full;
        w_wr_drop = wr_en && w_full;
        w_pop     = !pause && (r_count != '0);
    end

    // NOTE: the storage array has no reset; stale entries are unreachable once the pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (!reset && w_wr_acc) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_char     <= FILL;
            r_char_vld <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end

            if (w_wr_drop) begin
                r_ovf <= 1'b1;
            end

            // While paused the presented char and read pointer hold.
            if (!pause) begin
                if (w_pop) begin
                    r_char     <= r_mem[r_rd_ptr];
                    r_char_vld <= 1'b1;
                    r_rd_ptr   <= r_rd_ptr + AW'(1);
                end else begin
                    r_char     <= FILL;
                    r_char_vld <= 1'b0;
                end
            end

            case ({w_wr_acc, w_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign char     = r_char;
    assign char_vld = r_char_vld;
    assign full     = w_full;
    assign count    = r_count;
    assign ovf      = r_ovf;

endmodule

// File: tb/tb_char_feeder.sv
// Self-checking bench for char_feeder: vector table, directed corner sequences and
// randomized traffic against a queue-based reference model.
module tb_char_feeder;

    localparam int         DEPTH = 8;
    localparam logic [7:0] FILL  = 8'h20;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       pause;
    logic [7:0] char;
    logic       char_vld;
    logic       full;
    logic [3:0] count;
    logic       ovf;

    int n_checks = 0;
    int n_errors = 0;

    char_feeder #(.DEPTH(DEPTH), .FILL(FILL)) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .pause    (pause),
        .char     (char),
        .char_vld (char_vld),
        .full     (full),
        .count    (count),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       we;
        logic [7:0] wd;
        logic       pz;
        logic [7:0] ec;
        logic       ev;
        int         ecnt;
        logic       ef;
        logic       eo;
    } vec_t;

    vec_t vecs[$];

    // Reference model state: contents as a queue plus the presented outputs.
    logic [7:0] m_q[$];
    logic [7:0] m_char;
    logic       m_vld;
    logic       m_ovf;

    function automatic void add(input logic rst, input logic we, input logic [7:0] wd,
                                input logic pz, input logic [7:0] ec, input logic ev,
                                input int ecnt, input logic ef, input logic eo);
        vec_t v;
        v.rst = rst; v.we = we; v.wd = wd; v.pz = pz;
        v.ec = ec; v.ev = ev; v.ecnt = ecnt; v.ef = ef; v.eo = eo;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string name, input logic [7:0] ec, input logic ev,
                             input int ecnt, input logic ef, input logic eo);
        check({name, ".char"},  32'(char),     32'(ec));
        check({name, ".vld"},   32'(char_vld), 32'(ev));
        check({name, ".count"}, 32'(count),    32'(ecnt));
        check({name, ".full"},  32'(full),     32'(ef));
        check({name, ".ovf"},   32'(ovf),      32'(eo));
    endtask

    // Apply inputs, let one rising edge pass, then settle before sampling.
    task automatic cyc(input logic rst, input logic we, input logic [7:0] wd, input logic pz);
        reset   = rst;
        wr_en   = we;
        wr_data = wd;
        pause   = pz;
        @(posedge clk);
        #1;
    endtask

    task automatic model_edge(input logic rst, input logic we, input logic [7:0] wd, input logic pz);
        int len;
        if (rst) begin
            m_q.delete();
            m_char = FILL;
            m_vld  = 1'b0;
            m_ovf  = 1'b0;
        end else begin
            len = m_q.size();
            if (!pz) begin
                if (len > 0) begin
                    m_char = m_q.pop_front();
                    m_vld  = 1'b1;
                end else begin
                    m_char = FILL;
                    m_vld  = 1'b0;
                end
            end
            if (we) begin
                if (len < DEPTH) m_q.push_back(wd);
                else             m_ovf = 1'b1;
            end
        end
    endtask

    task automatic rand_cycle(input logic rst, input logic we, input logic pz, input string name);
        logic [7:0] wd;
        wd = 8'($urandom_range(8'h21, 8'h7e));
        cyc(rst, we, wd, pz);
        model_edge(rst, we, wd, pz);
        check_all(name, m_char, m_vld, m_q.size(), m_q.size() == DEPTH, m_ovf);
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_data = '0; pause = 1'b0;

        // Basic stream, then fill with overflow under pause and drain.
        add(1, 0, 8'h00, 0, FILL, 0, 0, 0, 0);
        add(0, 1, "a",   0, FILL, 0, 1, 0, 0);
        add(0, 1, "1",   0, "a",  1, 1, 0, 0);
        add(0, 1, "b",   0, "1",  1, 1, 0, 0);
        add(0, 0, 8'h00, 0, "b",  1, 0, 0, 0);
        add(0, 0, 8'h00, 0, FILL, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) add(0, 1, 8'("A" + i), 1, FILL, 0, i + 1, i == 7, 0);
        add(0, 1, "I", 1, FILL, 0, 8, 1, 1);
        for (int i = 0; i < 8; i++) add(0, 0, 8'h00, 0, 8'("A" + i), 1, 7 - i, 0, 1);
        add(0, 0, 8'h00, 0, FILL, 0, 0, 0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].rst, vecs[i].we, vecs[i].wd, vecs[i].pz);
            check_all($sformatf("vec%0d", i), vecs[i].ec, vecs[i].ev, vecs[i].ecnt, vecs[i].ef, vecs[i].eo);
        end

        // Full buffer with a pop and a write on the same edge: the write is dropped.
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 8; i++) cyc(0, 1, 8'("p" + i), 1);
        check_all("sim_full", FILL, 0, 8, 1, 0);
        cyc(0, 1, "Z", 0);
        check_all("sim_drop", "p", 1, 7, 0, 1);
        for (int i = 1; i < 8; i++) begin
            cyc(0, 0, 0, 0);
            check_all($sformatf("sim_drain%0d", i), 8'("p" + i), 1, 7 - i, 0, 1);
        end
        cyc(0, 0, 0, 0);
        check_all("sim_noZ", FILL, 0, 0, 0, 1);

        // Accepted write plus pop at count 3 leaves count unchanged.
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 8'("0" + i), 1);
        cyc(0, 1, "w", 0);
        check_all("sim_wrpop", "0", 1, 3, 0, 0);

        // Pause holds the presented char while writes continue.
        cyc(1, 0, 0, 0);
        cyc(0, 1, "x", 0);
        cyc(0, 0, 0, 0);
        check_all("hold_x", "x", 1, 0, 0, 0);
        cyc(0, 1, "y", 1);
        check_all("hold0", "x", 1, 1, 0, 0);
        for (int i = 1; i < 4; i++) begin
            cyc(0, 0, 0, 1);
            check_all($sformatf("hold%0d", i), "x", 1, 1, 0, 0);
        end
        cyc(0, 0, 0, 0);
        check_all("hold_rel", "y", 1, 0, 0, 0);

        // Reset mid-stream with a coincident write.
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 9; i++) cyc(0, 1, 8'("k" + i), 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
        check_all("rst_pre", "m", 1, 5, 0, 1);
        cyc(1, 1, "Q", 0);
        check_all("rst_mid", FILL, 0, 0, 0, 0);
        cyc(0, 1, "R", 0);
        check_all("rst_first_wr", FILL, 0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        check_all("rst_first_rd", "R", 1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        check_all("rst_noQ", FILL, 0, 0, 0, 0);

        // Interleaved traffic at low occupancy across several pointer wraps.
        rand_cycle(1, 0, 0, "wrap_rst");
        begin
            int accepted = 0;
            for (int c = 0; c < 200 && accepted < 20; c++) begin
                logic we, pz;
                we = ($urandom_range(0, 3) != 0) && (m_q.size() < 2);
                pz = ($urandom_range(0, 2) == 0);
                if (we) accepted++;
                rand_cycle(0, we, pz, "wrap");
                check("wrap_occ", 32'(count <= 2), 32'd1);
            end
            check("wrap_accepted", 32'(accepted), 32'd20);
        end

        // Randomized traffic including pauses, bursts to full and occasional resets.
        rand_cycle(1, 0, 0, "rnd_rst");
        for (int c = 0; c < 1500; c++) begin
            logic rst, we, pz;
            rst = ($urandom_range(0, 199) == 0);
            we  = ($urandom_range(0, 9) < 6);
            pz  = ($urandom_range(0, 9) < ((c / 250) % 2 == 0 ? 6 : 2));
            rand_cycle(rst, we, pz, "rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
